uart_fifo_sync: RTL and testbench

- Single-clock, parametrised successor to the UART dual-clock FIFO.
- Buffers UART TX/RX bytes (or wider words) between the UART core and the CPU bus interface.
- Adds full-depth usage (no wasted slot), a registered output stage with valid/ready hold, programmable almost-full/almost-empty flags, synchronous flush, and a saturating overflow counter.

---
 rtl/uart_fifo_sync_pkg.sv | 12 +
 rtl/fifo_dpram.sv | 29 ++
 rtl/uart_fifo_sync.sv | 116 +++++++++++
 tb/tb_uart_fifo_sync.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_fifo_sync_pkg.sv
// Shared definitions for the single-clock UART FIFO: default instance sizing
// and the RAM depth derivation used by the top and the storage array.
package uart_fifo_sync_pkg;

    localparam int UART_WIDTH      = 8;
    localparam int UART_DEPTH_BITS = 7;

    function automatic int fifo_depth(input int depth_bits);
        return 1 << depth_bits;
    endfunction

endpackage

// File: rtl/fifo_dpram.sv
// DEPTH x WIDTH storage with synchronous write and asynchronous read.
// Contents are deliberately not reset.
module fifo_dpram
    import uart_fifo_sync_pkg::*;
#(
    parameter int WIDTH      = UART_WIDTH,
    parameter int DEPTH_BITS = UART_DEPTH_BITS
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [DEPTH_BITS-1:0] i_waddr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic [DEPTH_BITS-1:0] i_raddr,
    output logic [WIDTH-1:0]      o_rdata
);

    localparam int DEPTH = fifo_depth(DEPTH_BITS);

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_fifo_sync.sv
// Single-clock FIFO between the UART core and the CPU bus: full-depth RAM,
// registered output stage, level flags, flush and saturating overflow count.
module uart_fifo_sync
    import uart_fifo_sync_pkg::*;
#(
    parameter int WIDTH      = UART_WIDTH,
    parameter int DEPTH_BITS = UART_DEPTH_BITS,
    parameter int AF_LEVEL   = 120,
    parameter int AE_LEVEL   = 4,
    parameter int OVF_BITS   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WIDTH-1:0]      s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [WIDTH-1:0]      m_data,
    output logic [DEPTH_BITS:0]   level,
    output logic                  almost_full,
    output logic                  almost_empty,
    input  logic                  clr_ovf,
    output logic [OVF_BITS-1:0]   ovf_cnt
);

    localparam int                    DEPTH    = fifo_depth(DEPTH_BITS);
    localparam logic [DEPTH_BITS:0]   CNT_FULL = (DEPTH_BITS+1)'(DEPTH);
    localparam logic [DEPTH_BITS:0]   CNT_ONE  = 1;
    localparam logic [DEPTH_BITS-1:0] PTR_ONE  = 1;
    localparam logic [OVF_BITS-1:0]   OVF_ONE  = 1;
    localparam logic [OVF_BITS-1:0]   OVF_MAX  = '1;

    logic [DEPTH_BITS-1:0] r_wr_ptr;
    logic [DEPTH_BITS-1:0] r_rd_ptr;
    logic [DEPTH_BITS:0]   r_ram_cnt;
    logic                  r_m_valid;
    logic [WIDTH-1:0]      r_m_data;
    logic [OVF_BITS-1:0]   r_ovf_cnt;

    logic                  w_s_ready;
    logic                  w_wr;
    logic                  w_load;
    logic                  w_reject;
    logic [WIDTH-1:0]      w_rd_data;
    logic [DEPTH_BITS:0]   w_level;

    // Ready comes only from registered count, so a same-cycle pop never frees a slot.
    assign w_s_ready = (r_ram_cnt != CNT_FULL);
    assign w_wr      = s_valid & w_s_ready & ~flush;
    assign w_reject  = s_valid & ~w_s_ready & ~flush;
    assign w_load    = (~r_m_valid | m_ready) & (r_ram_cnt != '0) & ~flush;
    assign w_level   = r_ram_cnt + {{DEPTH_BITS{1'b0}}, r_m_valid};

    fifo_dpram #(
        .WIDTH      (WIDTH),
        .DEPTH_BITS (DEPTH_BITS)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr),
        .i_waddr (r_wr_ptr),
        .i_wdata (s_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_ram_cnt <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
        end else if (flush) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_ram_cnt <= '0;
            r_m_valid <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_load) begin
                r_m_data  <= w_rd_data;
                r_m_valid <= 1'b1;
                r_rd_ptr  <= r_rd_ptr + PTR_ONE;
            end else if (m_ready) begin
                r_m_valid <= 1'b0;
            end
            case ({w_wr, w_load})
                2'b10:   r_ram_cnt <= r_ram_cnt + CNT_ONE;
                2'b01:   r_ram_cnt <= r_ram_cnt - CNT_ONE;
                default: r_ram_cnt <= r_ram_cnt;
            endcase
        end
    end

    // Overflow count survives flush; clear wins over a concurrent rejected write.
    always_ff @(posedge clk) begin
        if (rst || clr_ovf) begin
            r_ovf_cnt <= '0;
        end else if (w_reject && (r_ovf_cnt != OVF_MAX)) begin
            r_ovf_cnt <= r_ovf_cnt + OVF_ONE;
        end
    end

    assign s_ready      = w_s_ready;
    assign m_valid      = r_m_valid;
    assign m_data       = r_m_data;
    assign level        = w_level;
    assign almost_full  = (32'(w_level) >= AF_LEVEL);
    assign almost_empty = (32'(w_level) <= AE_LEVEL);
    assign ovf_cnt      = r_ovf_cnt;

endmodule

// File: tb/tb_uart_fifo_sync.sv
// Self-checking bench for uart_fifo_sync (DEPTH=4, AF=3, AE=1, 2-bit overflow
// counter): directed scenarios plus randomized traffic against a queue model.
module tb_uart_fifo_sync;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [2:0] level;
    logic       almost_full;
    logic       almost_empty;
    logic       clr_ovf;
    logic [1:0] ovf_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: RAM contents as a queue plus the output holding register.
    logic [7:0] mdl_q[$];
    bit         mdl_mv;
    logic [7:0] mdl_md;
    int         mdl_ovf;

    uart_fifo_sync #(
        .WIDTH      (8),
        .DEPTH_BITS (2),
        .AF_LEVEL   (3),
        .AE_LEVEL   (1),
        .OVF_BITS   (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .clr_ovf      (clr_ovf),
        .ovf_cnt      (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input bit sv, input logic [7:0] sd, input bit mr,
                         input bit fl, input bit co, input bit rs);
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        flush   = fl;
        clr_ovf = co;
        rst     = rs;
    endtask

    // Advance one clock and move the model forward using the inputs seen at the edge.
    task automatic tick();
        bit         rdy = (mdl_q.size() != 4);
        bit         sv  = s_valid;
        bit         mr  = m_ready;
        bit         fl  = flush;
        bit         co  = clr_ovf;
        bit         rs  = rst;
        logic [7:0] sd  = s_data;
        bit         wr  = sv && rdy && !fl;
        bit         ld  = (!mdl_mv || mr) && (mdl_q.size() != 0) && !fl;
        @(posedge clk);
        #1;
        if (rs) begin
            mdl_q.delete();
            mdl_mv  = 1'b0;
            mdl_md  = 8'h00;
            mdl_ovf = 0;
        end else begin
            if (co) mdl_ovf = 0;
            else if (sv && !rdy && !fl && mdl_ovf < 3) mdl_ovf++;
            if (fl) begin
                mdl_q.delete();
                mdl_mv = 1'b0;
            end else begin
                if (ld) begin
                    mdl_md = mdl_q.pop_front();
                    mdl_mv = 1'b1;
                end else if (mr) begin
                    mdl_mv = 1'b0;
                end
                if (wr) mdl_q.push_back(sd);
            end
        end
    endtask

    task automatic do_reset();
        drive(0, 8'h00, 0, 0, 0, 1);
        tick();
        drive(0, 8'h00, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        drive(0, 8'h00, 0, 0, 0, 1);
        tick();
        tick();
        drive(0, 8'h00, 0, 0, 0, 0);
        n_checks++; if (s_ready !== 1'b1) begin n_errors++; $display("FAIL reset_s_ready got=%0b exp=1", s_ready); end
        n_checks++; if (m_valid !== 1'b0) begin n_errors++; $display("FAIL reset_m_valid got=%0b exp=0", m_valid); end
        n_checks++; if (m_data !== 8'h00) begin n_errors++; $display("FAIL reset_m_data got=%02h exp=00", m_data); end
        n_checks++; if (level !== 3'd0) begin n_errors++; $display("FAIL reset_level got=%0d exp=0", level); end
        n_checks++; if (almost_empty !== 1'b1) begin n_errors++; $display("FAIL reset_ae got=%0b exp=1", almost_empty); end
        n_checks++; if (almost_full !== 1'b0) begin n_errors++; $display("FAIL reset_af got=%0b exp=0", almost_full); end
        n_checks++; if (ovf_cnt !== 2'd0) begin n_errors++; $display("FAIL reset_ovf got=%0d exp=0", ovf_cnt); end
        $display("test_reset done");
    endtask

    task automatic test_latency();
        do_reset();
        drive(1, 8'hA5, 1, 0, 0, 0);
        tick();
        drive(0, 8'h00, 1, 0, 0, 0);
        n_checks++; if (m_valid !== 1'b0 || level !== 3'd1) begin n_errors++; $display("FAIL lat_c1 got mv=%0b lvl=%0d exp mv=0 lvl=1", m_valid, level); end
        tick();
        n_checks++; if (m_valid !== 1'b1 || m_data !== 8'hA5 || level !== 3'd1) begin n_errors++; $display("FAIL lat_c2 got mv=%0b d=%02h lvl=%0d exp mv=1 d=a5 lvl=1", m_valid, m_data, level); end
        tick();
        n_checks++; if (m_valid !== 1'b0 || level !== 3'd0) begin n_errors++; $display("FAIL lat_c3 got mv=%0b lvl=%0d exp mv=0 lvl=0", m_valid, level); end
        $display("test_latency done");
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1, 8'(8'h11 + i), 0, 0, 0, 0);
            if (i == 5) begin
                n_checks++; if (s_ready !== 1'b0) begin n_errors++; $display("FAIL fill_s_ready got=%0b exp=0", s_ready); end
            end else begin
                n_checks++; if (s_ready !== 1'b1) begin n_errors++; $display("FAIL fill_accept%0d got=%0b exp=1", i, s_ready); end
            end
            tick();
        end
        drive(0, 8'h00, 0, 0, 0, 0);
        n_checks++; if (level !== 3'd5) begin n_errors++; $display("FAIL fill_level got=%0d exp=5", level); end
        n_checks++; if (almost_full !== 1'b1) begin n_errors++; $display("FAIL fill_af got=%0b exp=1", almost_full); end
        n_checks++; if (ovf_cnt !== 2'd1) begin n_errors++; $display("FAIL fill_ovf got=%0d exp=1", ovf_cnt); end
        drive(0, 8'h00, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== 8'(8'h11 + i)) begin
                n_errors++; $display("FAIL fill_drain%0d got mv=%0b d=%02h exp mv=1 d=%02h", i, m_valid, m_data, 8'(8'h11 + i));
            end
            tick();
        end
        n_checks++; if (m_valid !== 1'b0 || almost_empty !== 1'b1) begin n_errors++; $display("FAIL fill_empty got mv=%0b ae=%0b exp mv=0 ae=1", m_valid, almost_empty); end
        $display("test_fill done");
    endtask

    task automatic test_stream();
        do_reset();
        for (int c = 0; c < 13; c++) begin
            drive(c < 11, 8'(c), 1, 0, 0, 0);
            if (c < 11) begin
                n_checks++; if (s_ready !== 1'b1) begin n_errors++; $display("FAIL stream_ready c=%0d got=%0b exp=1", c, s_ready); end
            end
            tick();
            if (c >= 1 && c <= 11) begin
                n_checks++;
                if (m_valid !== 1'b1 || m_data !== 8'(c - 1)) begin
                    n_errors++; $display("FAIL stream_out c=%0d got mv=%0b d=%02h exp mv=1 d=%02h", c, m_valid, m_data, 8'(c - 1));
                end
            end
        end
        n_checks++; if (m_valid !== 1'b0) begin n_errors++; $display("FAIL stream_end got mv=%0b exp=0", m_valid); end
        $display("test_stream done");
    endtask

    task automatic test_flush();
        logic [1:0] ovf_before;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1, 8'(8'h40 + i), 0, 0, 0, 0);
            tick();
        end
        drive(0, 8'h00, 1, 0, 0, 0);
        tick();
        tick();
        drive(0, 8'h00, 0, 0, 0, 0);
        n_checks++; if (level !== 3'd3) begin n_errors++; $display("FAIL flush_pre_level got=%0d exp=3", level); end
        ovf_before = ovf_cnt;
        drive(1, 8'h77, 0, 1, 0, 0);
        tick();
        drive(0, 8'h00, 1, 0, 0, 0);
        n_checks++; if (level !== 3'd0 || m_valid !== 1'b0 || s_ready !== 1'b1) begin n_errors++; $display("FAIL flush_state got lvl=%0d mv=%0b rdy=%0b exp lvl=0 mv=0 rdy=1", level, m_valid, s_ready); end
        n_checks++; if (ovf_cnt !== 2'd1) begin n_errors++; $display("FAIL flush_ovf got=%0d exp=1 (before=%0d)", ovf_cnt, ovf_before); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (m_valid !== 1'b0) begin n_errors++; $display("FAIL flush_leak got mv=%0b d=%02h exp mv=0", m_valid, m_data); end
        end
        $display("test_flush done");
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 8'(i), 0, 0, 0, 0);
            tick();
        end
        n_checks++; if (s_ready !== 1'b0 || ovf_cnt !== 2'd0) begin n_errors++; $display("FAIL ovf_full got rdy=%0b ovf=%0d exp rdy=0 ovf=0", s_ready, ovf_cnt); end
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_checks++; if (ovf_cnt !== 2'((k > 3) ? 3 : k)) begin n_errors++; $display("FAIL ovf_sat k=%0d got=%0d exp=%0d", k, ovf_cnt, (k > 3) ? 3 : k); end
        end
        drive(0, 8'h00, 0, 0, 1, 0);
        tick();
        n_checks++; if (ovf_cnt !== 2'd0) begin n_errors++; $display("FAIL ovf_clr got=%0d exp=0", ovf_cnt); end
        drive(1, 8'hEE, 0, 0, 0, 0);
        tick();
        n_checks++; if (ovf_cnt !== 2'd1) begin n_errors++; $display("FAIL ovf_recount got=%0d exp=1", ovf_cnt); end
        drive(1, 8'hEE, 0, 0, 1, 0);
        tick();
        n_checks++; if (ovf_cnt !== 2'd0) begin n_errors++; $display("FAIL ovf_clr_prio got=%0d exp=0", ovf_cnt); end
        drive(0, 8'h00, 0, 0, 0, 0);
        $display("test_overflow done");
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1, 8'(8'h60 + i), 0, 0, 0, 0);
            tick();
        end
        drive(0, 8'h00, 0, 0, 0, 0);
        tick();
        n_checks++; if (ovf_cnt === 2'd0) begin n_errors++; $display("FAIL mid_pre_ovf got=%0d exp=nonzero", ovf_cnt); end
        drive(0, 8'h00, 1, 0, 0, 0);
        tick();
        drive(0, 8'h00, 0, 0, 0, 0);
        n_checks++; if (level !== 3'd4 || m_valid !== 1'b1) begin n_errors++; $display("FAIL mid_pre got lvl=%0d mv=%0b exp lvl=4 mv=1", level, m_valid); end
        drive(0, 8'h00, 0, 0, 0, 1);
        tick();
        drive(0, 8'h00, 0, 0, 0, 0);
        n_checks++; if (m_valid !== 1'b0 || m_data !== 8'h00 || level !== 3'd0 || ovf_cnt !== 2'd0) begin n_errors++; $display("FAIL mid_reset got mv=%0b d=%02h lvl=%0d ovf=%0d exp 0 00 0 0", m_valid, m_data, level, ovf_cnt); end
        drive(1, 8'h3C, 1, 0, 0, 0);
        tick();
        drive(0, 8'h00, 1, 0, 0, 0);
        n_checks++; if (m_valid !== 1'b0) begin n_errors++; $display("FAIL mid_early got mv=%0b exp=0", m_valid); end
        tick();
        n_checks++; if (m_valid !== 1'b1 || m_data !== 8'h3C) begin n_errors++; $display("FAIL mid_write got mv=%0b d=%02h exp mv=1 d=3c", m_valid, m_data); end
        $display("test_reset_midstream done");
    endtask

    task automatic test_random();
        int mlvl;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 149) == 0);
            n_checks++; if (s_ready !== (mdl_q.size() != 4)) begin n_errors++; $display("FAIL rnd_ready c=%0d got=%0b exp=%0b", c, s_ready, mdl_q.size() != 4); end
            tick();
            mlvl = mdl_q.size() + int'(mdl_mv);
            n_checks++; if (m_valid !== mdl_mv) begin n_errors++; $display("FAIL rnd_valid c=%0d got=%0b exp=%0b", c, m_valid, mdl_mv); end
            n_checks++; if (m_data !== mdl_md) begin n_errors++; $display("FAIL rnd_data c=%0d got=%02h exp=%02h", c, m_data, mdl_md); end
            n_checks++; if (level !== 3'(mlvl)) begin n_errors++; $display("FAIL rnd_level c=%0d got=%0d exp=%0d", c, level, mlvl); end
            n_checks++; if (almost_full !== (mlvl >= 3) || almost_empty !== (mlvl <= 1)) begin n_errors++; $display("FAIL rnd_flags c=%0d got af=%0b ae=%0b lvl_exp=%0d", c, almost_full, almost_empty, mlvl); end
            n_checks++; if (ovf_cnt !== 2'(mdl_ovf)) begin n_errors++; $display("FAIL rnd_ovf c=%0d got=%0d exp=%0d", c, ovf_cnt, mdl_ovf); end
        end
        $display("test_random done");
    endtask

    initial begin
        drive(0, 8'h00, 0, 0, 0, 1);
        mdl_mv  = 1'b0;
        mdl_md  = 8'h00;
        mdl_ovf = 0;
        test_reset();
        test_latency();
        test_fill();
        test_stream();
        test_flush();
        test_overflow();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
